ysyx_22040759_mem_sched: RTL and testbench

Request scheduler between the core's fetch/load/store ports and the AXI read/write engines (rdaxi, wraxi). It arbitrates IF and MEM reads onto the single read engine: MEM has priority, with a starvation bound for IF. It posts MEM stores through a one-entry write buffer and blocks any read that hits the buffered store's 8-byte line until the store completes (RAW ordering). It replaces the direct reqDispute/arbiter path inside ysyx_22040759_axi.

---
 rtl/ysyx_22040759_mem_sched_pkg.sv | 7 +
 rtl/ysyx_22040759_mem_sched_if.sv | 41 ++++
 rtl/ysyx_22040759_wbuf.sv | 60 ++++++
 rtl/ysyx_22040759_mem_sched.sv | 95 +++++++++
 tb/tb_ysyx_22040759_mem_sched.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/ysyx_22040759_mem_sched_pkg.sv
// ysyx_22040759_mem_sched_pkg: state encodings and constants shared by the scheduler and its write buffer
package ysyx_22040759_mem_sched_pkg;
  typedef enum logic [1:0] {R_IDLE, R_IF, R_MEM, R_RESP} r_state_e;
  typedef enum logic {W_EMPTY, W_FULL} w_state_e;
  localparam logic [2:0] IF_SIZE = 3'b011;
  localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/ysyx_22040759_mem_sched_if.sv
// ysyx_22040759_mem_sched_if: core request ports and rdaxi/wraxi engine ports seen by the scheduler
interface ysyx_22040759_mem_sched_if #(parameter int ADDR_WIDTH = 64, parameter int DATA_WIDTH = 64);
  logic                  if_addr_valid_i;
  logic [ADDR_WIDTH-1:0] if_rd_addr_i;
  logic                  if_data_valid_o;
  logic [DATA_WIDTH-1:0] if_data_o;
  logic                  mem_rd_addr_valid_i;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_i;
  logic [2:0]            mem_rd_size_i;
  logic                  mem_rd_data_valid_o;
  logic [DATA_WIDTH-1:0] mem_rd_data_o;
  logic                  mem_wr_addr_valid_i;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_i;
  logic [2:0]            mem_wr_size_i;
  logic [DATA_WIDTH-1:0] mem_wr_data_i;
  logic                  mem_wr_data_valid_o;
  logic                  rd_addr_valid_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic [2:0]            rd_size_o;
  logic                  rd_data_valid_i;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic                  wr_addr_valid_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [2:0]            wr_size_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  wr_data_valid_i;
  modport slave (
    input  if_addr_valid_i, if_rd_addr_i, mem_rd_addr_valid_i, mem_rd_addr_i, mem_rd_size_i,
           mem_wr_addr_valid_i, mem_wr_addr_i, mem_wr_size_i, mem_wr_data_i,
           rd_data_valid_i, rd_data_i, wr_data_valid_i,
    output if_data_valid_o, if_data_o, mem_rd_data_valid_o, mem_rd_data_o, mem_wr_data_valid_o,
           rd_addr_valid_o, rd_addr_o, rd_size_o, wr_addr_valid_o, wr_addr_o, wr_size_o, wr_data_o
  );
  modport master (
    output if_addr_valid_i, if_rd_addr_i, mem_rd_addr_valid_i, mem_rd_addr_i, mem_rd_size_i,
           mem_wr_addr_valid_i, mem_wr_addr_i, mem_wr_size_i, mem_wr_data_i,
           rd_data_valid_i, rd_data_i, wr_data_valid_i,
    input  if_data_valid_o, if_data_o, mem_rd_data_valid_o, mem_rd_data_o, mem_wr_data_valid_o,
           rd_addr_valid_o, rd_addr_o, rd_size_o, wr_addr_valid_o, wr_addr_o, wr_size_o, wr_data_o
  );
endinterface

// File: rtl/ysyx_22040759_wbuf.sv
// ysyx_22040759_wbuf: one-entry posted store buffer with ack pulse and 8-byte line match for RAW blocking
module ysyx_22040759_wbuf
  import ysyx_22040759_mem_sched_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  input  logic [2:0]    i_size,
  input  logic [DW-1:0] i_data,
  input  logic          i_done,
  input  logic [AW-1:0] i_if_addr,
  input  logic [AW-1:0] i_mem_addr,
  output logic          o_ack,
  output logic          o_full,
  output logic [AW-1:0] o_addr,
  output logic [2:0]    o_size,
  output logic [DW-1:0] o_data,
  output logic          o_hit_if,
  output logic          o_hit_mem
);
  w_state_e      r_state;
  logic          r_ack;
  logic [AW-1:0] r_addr;
  logic [2:0]    r_size;
  logic [DW-1:0] r_data;
  logic          w_cap, w_busy;
  logic [AW-4:0] w_line;
  assign w_cap  = i_valid & (r_state == W_EMPTY) & ~r_ack;
  assign w_busy = w_cap | (r_state == W_FULL);
  // A store being captured this cycle already blocks reads to its line
  assign w_line    = w_cap ? i_addr[AW-1:3] : r_addr[AW-1:3];
  assign o_hit_if  = w_busy & (i_if_addr[AW-1:3] == w_line);
  assign o_hit_mem = w_busy & (i_mem_addr[AW-1:3] == w_line);
  assign o_ack  = r_ack;
  assign o_full = r_state == W_FULL;
  assign o_addr = r_addr;
  assign o_size = r_size;
  assign o_data = r_data;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state <= W_EMPTY;
      r_ack   <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_data  <= '0;
    end else begin
      r_ack <= w_cap;
      if (w_cap) begin
        r_state <= W_FULL;
        r_addr  <= i_addr;
        r_size  <= i_size;
        r_data  <= i_data;
      end else if (r_state == W_FULL && i_done)
        r_state <= W_EMPTY;
    end
endmodule

// File: rtl/ysyx_22040759_mem_sched.sv
// ysyx_22040759_mem_sched: arbitrates IF/MEM reads onto rdaxi (MEM priority, IF starvation bound)
// and posts MEM stores through a one-entry buffer with RAW blocking
module ysyx_22040759_mem_sched
  import ysyx_22040759_mem_sched_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic clock,
  input logic reset,
  ysyx_22040759_mem_sched_if.slave bus
);
  r_state_e              r_state;
  logic [3:0]            r_starve;
  logic                  r_rd_valid, r_if_valid, r_mem_valid;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [2:0]            r_rd_size;
  logic [DATA_WIDTH-1:0] r_if_data, r_mem_data;
  logic                  w_hit_if, w_hit_mem, w_if_el, w_mem_el, w_gnt_if, w_gnt_mem;
  ysyx_22040759_wbuf #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_wbuf (
    .clock     (clock),
    .reset     (reset),
    .i_valid   (bus.mem_wr_addr_valid_i),
    .i_addr    (bus.mem_wr_addr_i),
    .i_size    (bus.mem_wr_size_i),
    .i_data    (bus.mem_wr_data_i),
    .i_done    (bus.wr_data_valid_i),
    .i_if_addr (bus.if_rd_addr_i),
    .i_mem_addr(bus.mem_rd_addr_i),
    .o_ack     (bus.mem_wr_data_valid_o),
    .o_full    (bus.wr_addr_valid_o),
    .o_addr    (bus.wr_addr_o),
    .o_size    (bus.wr_size_o),
    .o_data    (bus.wr_data_o),
    .o_hit_if  (w_hit_if),
    .o_hit_mem (w_hit_mem)
  );
  assign w_if_el   = bus.if_addr_valid_i & ~w_hit_if;
  assign w_mem_el  = bus.mem_rd_addr_valid_i & ~w_hit_mem;
  assign w_gnt_if  = w_if_el & (~w_mem_el | (r_starve == 4'(STARVE_LIMIT)));
  assign w_gnt_mem = ~w_gnt_if & w_mem_el;
  assign bus.rd_addr_valid_o     = r_rd_valid;
  assign bus.rd_addr_o           = r_rd_addr;
  assign bus.rd_size_o           = r_rd_size;
  assign bus.if_data_valid_o     = r_if_valid;
  assign bus.if_data_o           = r_if_data;
  assign bus.mem_rd_data_valid_o = r_mem_valid;
  assign bus.mem_rd_data_o       = r_mem_data;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state     <= R_IDLE;
      r_starve    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_size   <= '0;
      r_if_valid  <= 1'b0;
      r_if_data   <= '0;
      r_mem_valid <= 1'b0;
      r_mem_data  <= '0;
    end else
      case (r_state)
        R_IDLE:
          if (w_gnt_if) begin
            r_state    <= R_IF;
            r_rd_valid <= 1'b1;
            r_rd_addr  <= bus.if_rd_addr_i;
            r_rd_size  <= IF_SIZE;
            r_starve   <= '0;
          end else if (w_gnt_mem) begin
            r_state    <= R_MEM;
            r_rd_valid <= 1'b1;
            r_rd_addr  <= bus.mem_rd_addr_i;
            r_rd_size  <= bus.mem_rd_size_i;
            r_starve   <= (bus.if_addr_valid_i && r_starve != 4'(STARVE_LIMIT)) ? r_starve + 4'd1 : r_starve;
          end
        R_IF, R_MEM:
          if (bus.rd_data_valid_i) begin
            r_state    <= R_RESP;
            r_rd_valid <= 1'b0;
            if (r_state == R_IF) begin
              r_if_valid <= 1'b1;
              r_if_data  <= bus.rd_data_i;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_data  <= bus.rd_data_i;
            end
          end
        default: begin
          r_state     <= R_IDLE;
          r_if_valid  <= 1'b0;
          r_mem_valid <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_ysyx_22040759_mem_sched.sv
// tb_ysyx_22040759_mem_sched: directed self-checking bench for the read arbiter and write buffer
module tb_ysyx_22040759_mem_sched;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  ysyx_22040759_mem_sched_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();
  ysyx_22040759_mem_sched dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_addr_valid_i = 0; bus.if_rd_addr_i = 0;
    bus.mem_rd_addr_valid_i = 0; bus.mem_rd_addr_i = 0; bus.mem_rd_size_i = 0;
    bus.mem_wr_addr_valid_i = 0; bus.mem_wr_addr_i = 0; bus.mem_wr_size_i = 0; bus.mem_wr_data_i = 0;
    bus.rd_data_valid_i = 0; bus.rd_data_i = 0; bus.wr_data_valid_i = 0;
    #3 reset = 1'b0;
    step(); step();
    chk("rst_rd_valid", 64'(bus.rd_addr_valid_o), 64'd0);
    chk("rst_wr_valid", 64'(bus.wr_addr_valid_o), 64'd0);
    chk("rst_if_valid", 64'(bus.if_data_valid_o), 64'd0);
    chk("rst_ack", 64'(bus.mem_wr_data_valid_o), 64'd0);
    chk("rst_rd_addr", bus.rd_addr_o, 64'd0);
    chk("rst_if_data", bus.if_data_o, 64'd0);
    @(negedge clock) reset = 1'b1;
    step();
    // lone IF fetch, rdaxi answers three cycles after the command
    bus.if_addr_valid_i = 1; bus.if_rd_addr_i = 64'h8000_0000;
    step();
    chk("if_cmd_valid", 64'(bus.rd_addr_valid_o), 64'd1);
    chk("if_cmd_addr", bus.rd_addr_o, 64'h8000_0000);
    chk("if_cmd_size", 64'(bus.rd_size_o), 64'd3);
    step(); step(); step();
    bus.rd_data_valid_i = 1; bus.rd_data_i = 64'h1234;
    step();
    bus.rd_data_valid_i = 0;
    chk("if_resp_valid", 64'(bus.if_data_valid_o), 64'd1);
    chk("if_resp_data", bus.if_data_o, 64'h1234);
    chk("if_cmd_drop", 64'(bus.rd_addr_valid_o), 64'd0);
    bus.if_addr_valid_i = 0;
    step();
    chk("if_resp_once", 64'(bus.if_data_valid_o), 64'd0);
    step();
    chk("if_no_dup", 64'(bus.rd_addr_valid_o), 64'd0);
    // both requesters held: M,M,M,M,I repeating
    bus.if_addr_valid_i = 1; bus.if_rd_addr_i = 64'h1000;
    bus.mem_rd_addr_valid_i = 1; bus.mem_rd_addr_i = 64'h2000; bus.mem_rd_size_i = 3'b010;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("starve_addr%0d", k), bus.rd_addr_o, (k % 5 == 4) ? 64'h1000 : 64'h2000);
      chk($sformatf("starve_size%0d", k), 64'(bus.rd_size_o), (k % 5 == 4) ? 64'd3 : 64'd2);
      bus.rd_data_valid_i = 1; bus.rd_data_i = 64'(k);
      step();
      bus.rd_data_valid_i = 0;
      chk($sformatf("starve_resp%0d", k),
          64'((k % 5 == 4) ? bus.if_data_valid_o : bus.mem_rd_data_valid_o), 64'd1);
      step();
    end
    bus.if_addr_valid_i = 0; bus.mem_rd_addr_valid_i = 0;
    step();
    // RAW: load to a buffered store's line waits for the store to drain
    bus.mem_wr_addr_valid_i = 1; bus.mem_wr_addr_i = 64'h8000_0010;
    bus.mem_wr_size_i = 3'b011; bus.mem_wr_data_i = 64'hdead;
    step();
    chk("st_ack", 64'(bus.mem_wr_data_valid_o), 64'd1);
    chk("st_wr_valid", 64'(bus.wr_addr_valid_o), 64'd1);
    chk("st_wr_addr", bus.wr_addr_o, 64'h8000_0010);
    chk("st_wr_data", bus.wr_data_o, 64'hdead);
    bus.mem_wr_addr_valid_i = 0;
    bus.mem_rd_addr_valid_i = 1; bus.mem_rd_addr_i = 64'h8000_0014; bus.mem_rd_size_i = 3'b010;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("raw_stall%0d", k), 64'(bus.rd_addr_valid_o), 64'd0);
    end
    chk("st_ack_once", 64'(bus.mem_wr_data_valid_o), 64'd0);
    bus.wr_data_valid_i = 1;
    step();
    bus.wr_data_valid_i = 0;
    chk("raw_wbuf_empty", 64'(bus.wr_addr_valid_o), 64'd0);
    chk("raw_still_low", 64'(bus.rd_addr_valid_o), 64'd0);
    step();
    chk("raw_issue", 64'(bus.rd_addr_valid_o), 64'd1);
    chk("raw_issue_addr", bus.rd_addr_o, 64'h8000_0014);
    bus.rd_data_valid_i = 1; bus.rd_data_i = 64'h55;
    step();
    bus.rd_data_valid_i = 0;
    chk("raw_resp_valid", 64'(bus.mem_rd_data_valid_o), 64'd1);
    chk("raw_resp_data", bus.mem_rd_data_o, 64'h55);
    bus.mem_rd_addr_valid_i = 0;
    step();
    // store and unrelated fetch run concurrently
    bus.mem_wr_addr_valid_i = 1; bus.mem_wr_addr_i = 64'h8000_0010; bus.mem_wr_data_i = 64'hcafe;
    bus.if_addr_valid_i = 1; bus.if_rd_addr_i = 64'h8000_0100;
    step();
    chk("conc_wr", 64'(bus.wr_addr_valid_o), 64'd1);
    chk("conc_rd", 64'(bus.rd_addr_valid_o), 64'd1);
    chk("conc_rd_addr", bus.rd_addr_o, 64'h8000_0100);
    // second store held while the buffer is full
    bus.mem_wr_addr_i = 64'h8000_0020; bus.mem_wr_data_i = 64'hbeef;
    bus.rd_data_valid_i = 1; bus.rd_data_i = 64'h77;
    step();
    bus.rd_data_valid_i = 0;
    chk("conc_if_resp", bus.if_data_o, 64'h77);
    chk("full_no_ack0", 64'(bus.mem_wr_data_valid_o), 64'd0);
    bus.if_addr_valid_i = 0;
    step();
    chk("full_no_ack1", 64'(bus.mem_wr_data_valid_o), 64'd0);
    chk("full_hold_addr", bus.wr_addr_o, 64'h8000_0010);
    bus.wr_data_valid_i = 1;
    step();
    bus.wr_data_valid_i = 0;
    chk("full_k1_ack", 64'(bus.mem_wr_data_valid_o), 64'd0);
    chk("full_k1_empty", 64'(bus.wr_addr_valid_o), 64'd0);
    step();
    chk("full_k2_ack", 64'(bus.mem_wr_data_valid_o), 64'd1);
    chk("full_k2_addr", bus.wr_addr_o, 64'h8000_0020);
    chk("full_k2_data", bus.wr_data_o, 64'hbeef);
    bus.mem_wr_addr_valid_i = 0;
    // reset while a MEM read is outstanding and the buffer is full
    bus.mem_rd_addr_valid_i = 1; bus.mem_rd_addr_i = 64'h3000; bus.mem_rd_size_i = 3'b011;
    step();
    chk("pre_rst_rd", 64'(bus.rd_addr_valid_o), 64'd1);
    chk("pre_rst_wr", 64'(bus.wr_addr_valid_o), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_rd", 64'(bus.rd_addr_valid_o), 64'd0);
    chk("mid_rst_wr", 64'(bus.wr_addr_valid_o), 64'd0);
    chk("mid_rst_ack", 64'(bus.mem_wr_data_valid_o), 64'd0);
    chk("mid_rst_rd_addr", bus.rd_addr_o, 64'd0);
    chk("mid_rst_wr_addr", bus.wr_addr_o, 64'd0);
    bus.mem_rd_addr_valid_i = 0;
    @(negedge clock) reset = 1'b1;
    bus.if_addr_valid_i = 1; bus.if_rd_addr_i = 64'h4000;
    step();
    chk("post_rst_valid", 64'(bus.rd_addr_valid_o), 64'd1);
    chk("post_rst_addr", bus.rd_addr_o, 64'h4000);
    bus.rd_data_valid_i = 1; bus.rd_data_i = 64'h99;
    step();
    bus.rd_data_valid_i = 0;
    chk("post_rst_resp", bus.if_data_o, 64'h99);
    bus.if_addr_valid_i = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
